// File: rtl/voice_gain_mixer.sv
// Multi-voice mixer: sequential per-voice gain MAC through one multiplier,
// enable masking, headroom shift and saturation of the final mix.
module voice_gain_mixer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_VOICES = 8,
  parameter int GAIN_WIDTH = 16,
  parameter int MIX_SHIFT  = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH*NUM_VOICES-1:0] voice_in_flat,
  input  logic [GAIN_WIDTH*NUM_VOICES-1:0] gain_in_flat,
  input  logic [NUM_VOICES-1:0]            voice_enable,
  input  logic                             data_in_valid,
  output logic [DATA_WIDTH-1:0]            mixed_out,
  output logic                             data_out_valid,
  output logic                             busy,
  output logic                             overrun,
  input  logic                             overrun_clr
);

  localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int PROD_W = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam int ACC_W  = PROD_W + $clog2(NUM_VOICES);
  localparam int SHIFT  = GAIN_WIDTH - 1 + MIX_SHIFT;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                           state_q, state_d;
  logic [DATA_WIDTH*NUM_VOICES-1:0] voice_q, voice_d;
  logic [GAIN_WIDTH*NUM_VOICES-1:0] gain_q, gain_d;
  logic [NUM_VOICES-1:0]            enable_q, enable_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic signed [ACC_W-1:0]          acc_q, acc_d;
  logic [DATA_WIDTH-1:0]            mixed_out_q, mixed_out_d;
  logic                             data_out_valid_q, data_out_valid_d;
  logic                             busy_q, busy_d;
  logic                             overrun_q, overrun_d;

  logic [DATA_WIDTH-1:0]            voice_sel_s;
  logic [GAIN_WIDTH-1:0]            gain_sel_s;
  logic signed [PROD_W-1:0]         prod_s;
  logic signed [ACC_W-1:0]          shifted_s;

  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [ACC_W-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    if (v > SAT_MAX) begin
      r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (v < SAT_MIN) begin
      r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      r = v[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  // Gain is zero-extended so full-scale unsigned gains stay positive.
  assign voice_sel_s = voice_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign gain_sel_s  = gain_q[idx_q*GAIN_WIDTH +: GAIN_WIDTH];
  assign prod_s      = PROD_W'($signed(voice_sel_s)) * PROD_W'($signed({1'b0, gain_sel_s}));
  assign shifted_s   = acc_q >>> SHIFT;

  always_comb begin
    state_d          = state_q;
    voice_d          = voice_q;
    gain_d           = gain_q;
    enable_d         = enable_q;
    idx_d            = idx_q;
    acc_d            = acc_q;
    mixed_out_d      = mixed_out_q;
    data_out_valid_d = 1'b0;
    overrun_d        = overrun_q;

    case (state_q)
      IDLE: begin
        if (data_in_valid) begin
          voice_d  = voice_in_flat;
          gain_d   = gain_in_flat;
          enable_d = voice_enable;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (enable_q[idx_q]) begin
          acc_d = acc_q + ACC_W'(prod_s);
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        mixed_out_d      = sat(shifted_s);
        data_out_valid_d = 1'b1;
        state_d          = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new drop outranks a same-cycle clear.
    if (data_in_valid && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      voice_q          <= '0;
      gain_q           <= '0;
      enable_q         <= '0;
      idx_q            <= '0;
      acc_q            <= '0;
      mixed_out_q      <= '0;
      data_out_valid_q <= 1'b0;
      busy_q           <= 1'b0;
      overrun_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      voice_q          <= voice_d;
      gain_q           <= gain_d;
      enable_q         <= enable_d;
      idx_q            <= idx_d;
      acc_q            <= acc_d;
      mixed_out_q      <= mixed_out_d;
      data_out_valid_q <= data_out_valid_d;
      busy_q           <= busy_d;
      overrun_q        <= overrun_d;
    end
  end

  assign mixed_out      = mixed_out_q;
  assign data_out_valid = data_out_valid_q;
  assign busy           = busy_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_voice_gain_mixer.sv
// Randomised and directed bench for voice_gain_mixer against a frame-level
// arithmetic model (integer mix, timing from acceptance cycle).
module tb_voice_gain_mixer;

  localparam int DW = 32;
  localparam int NV = 8;
  localparam int GW = 16;
  localparam int MS = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DW*NV-1:0]  voice_in_flat = '0;
  logic [GW*NV-1:0]  gain_in_flat = '0;
  logic [NV-1:0]     voice_enable = '0;
  logic              data_in_valid = 1'b0;
  logic              overrun_clr = 1'b0;
  logic [DW-1:0]     mixed_out;
  logic              data_out_valid;
  logic              busy;
  logic              overrun;

  int checks = 0;
  int errors = 0;

  voice_gain_mixer #(.DATA_WIDTH(DW), .NUM_VOICES(NV), .GAIN_WIDTH(GW), .MIX_SHIFT(MS)) dut (
    .clk(clk), .rst(rst), .voice_in_flat(voice_in_flat), .gain_in_flat(gain_in_flat),
    .voice_enable(voice_enable), .data_in_valid(data_in_valid), .mixed_out(mixed_out),
    .data_out_valid(data_out_valid), .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference mix: exact integer sum, floor shift, clamp.
  function automatic logic [31:0] mix_ref(input logic [DW*NV-1:0] v, input logic [GW*NV-1:0] g,
                                          input logic [NV-1:0] en);
    longint sum;
    sum = 0;
    for (int i = 0; i < NV; i++) begin
      if (en[i]) sum += longint'($signed(v[i*DW +: DW])) * longint'(g[i*GW +: GW]);
    end
    sum = sum >>> (GW - 1 + MS);
    if (sum > 64'sd2147483647) sum = 64'sd2147483647;
    if (sum < -64'sd2147483648) sum = -64'sd2147483648;
    return sum[31:0];
  endfunction

  longint      cyc = 0;
  longint      free_at = 0;
  longint      due_q[$];
  logic [31:0] val_q[$];
  logic [31:0] mix_m = '0;
  logic        dv_m = 1'b0;
  logic        ovr_m = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      due_q.delete();
      val_q.delete();
      free_at = 0;
      mix_m = '0;
      dv_m = 1'b0;
      ovr_m = 1'b0;
    end else begin
      cyc++;
      if (data_in_valid && cyc < free_at) ovr_m = 1'b1;
      else if (overrun_clr) ovr_m = 1'b0;
      if (data_in_valid && cyc >= free_at) begin
        due_q.push_back(cyc + NV + 1);
        val_q.push_back(mix_ref(voice_in_flat, gain_in_flat, voice_enable));
        free_at = cyc + NV + 2;
      end
      dv_m = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        dv_m = 1'b1;
        mix_m = val_q.pop_front();
        void'(due_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    chk("mixed_out", mixed_out, mix_m);
    chk("data_out_valid", 32'(data_out_valid), 32'(dv_m));
    chk("busy", 32'(busy), 32'(cyc < free_at - 1));
    chk("overrun", 32'(overrun), 32'(ovr_m));
  end

  // Call at a negedge with the DUT idle; checks latency and value literally.
  task automatic run_frame(input logic [DW*NV-1:0] v, input logic [GW*NV-1:0] g,
                           input logic [NV-1:0] en, input logic [31:0] exp, input string name);
    int lat;
    lat = 0;
    voice_in_flat = v;
    gain_in_flat  = g;
    voice_enable  = en;
    data_in_valid = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) data_in_valid = 1'b0;
      if (data_out_valid) begin
        lat = i;
        break;
      end
    end
    chk({name, "_latency"}, 32'(lat), 32'd10);
    chk(name, mixed_out, exp);
  endtask

  logic [DW*NV-1:0] v_t;
  logic [GW*NV-1:0] g_t;
  int               dv_cnt;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_mixed_out", mixed_out, 32'd0);
    chk("reset_dv", 32'(data_out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    @(negedge clk);

    run_frame({NV{32'd1000}}, {NV{16'h8000}}, 8'hFF, 32'd1000, "unity");
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      v_t[i*DW +: DW] = $urandom;
      g_t[i*GW +: GW] = 16'($urandom);
    end
    v_t[31:0]  = 32'sd8000;
    v_t[63:32] = -32'sd8000;
    g_t[15:0]  = 16'h4000;
    g_t[31:16] = 16'h8000;
    run_frame(v_t, g_t, 8'h03, -32'sd500, "gain_mask");
    @(negedge clk);
    run_frame({NV{32'h7FFFFFFF}}, {NV{16'hFFFF}}, 8'hFF, 32'h7FFFFFFF, "sat_pos");
    @(negedge clk);
    run_frame({NV{32'h80000000}}, {NV{16'hFFFF}}, 8'hFF, 32'h80000000, "sat_neg");
    @(negedge clk);
    run_frame(v_t, g_t, 8'h00, 32'd0, "all_masked");

    // Overrun: second strobe three cycles into the frame.
    voice_in_flat = {NV{32'd1000}};
    gain_in_flat  = {NV{16'h8000}};
    voice_enable  = 8'hFF;
    data_in_valid = 1'b1;
    dv_cnt = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == 1) data_in_valid = 1'b0;
      if (i == 3) data_in_valid = 1'b1;
      if (i == 4) data_in_valid = 1'b0;
      if (data_out_valid) dv_cnt++;
    end
    chk("overrun_single_strobe", 32'(dv_cnt), 32'd1);
    chk("overrun_set", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("overrun_clear", 32'(overrun), 32'd0);

    // Set beats clear when both land on the same edge.
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    @(negedge clk);
    data_in_valid = 1'b1;
    overrun_clr   = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
    overrun_clr   = 1'b0;
    chk("overrun_set_wins", 32'(overrun), 32'd1);
    repeat (12) @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;

    // Back-to-back: second strobe on the first cycle busy is low.
    run_frame({NV{32'd1000}}, {NV{16'h8000}}, 8'hFF, 32'd1000, "b2b_first");
    chk("b2b_busy_low", 32'(busy), 32'd0);
    run_frame(v_t, g_t, 8'h03, -32'sd500, "b2b_second");
    chk("b2b_no_overrun", 32'(overrun), 32'd0);

    // Reset in the middle of accumulation.
    voice_in_flat = {NV{32'd1000}};
    gain_in_flat  = {NV{16'h8000}};
    voice_enable  = 8'hFF;
    data_in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) data_in_valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("midrst_mixed_out", mixed_out, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_dv", 32'(data_out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dv_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (data_out_valid) dv_cnt++;
    end
    chk("midrst_no_strobe", 32'(dv_cnt), 32'd0);
    run_frame(v_t, g_t, 8'h03, -32'sd500, "after_reset");

    // Random traffic; inputs churn every cycle, including mid-frame.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < NV; i++) begin
        case ($urandom_range(0, 3))
          0: voice_in_flat[i*DW +: DW] = ($urandom_range(0, 1) == 0) ? 32'h7FFFFFFF : 32'h80000000;
          1: voice_in_flat[i*DW +: DW] = 32'($urandom_range(0, 4000)) - 32'd2000;
          default: voice_in_flat[i*DW +: DW] = $urandom;
        endcase
        gain_in_flat[i*GW +: GW] = 16'($urandom);
      end
      voice_enable  = 8'($urandom);
      data_in_valid = ($urandom_range(0, 7) == 0);
      overrun_clr   = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    data_in_valid = 1'b0;
    overrun_clr   = 1'b0;
    repeat (15) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
